store_buffer: RTL and testbench



---
 rtl/store_buffer.sv | 228 ++++++++++++++++++++++
 tb/tb_store_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer -- posted-write buffer in front of the single-port data memory.
//
// Stores from the core are queued in a small circular FIFO of {addr, data} and
// drained into memory one per cycle whenever the memory port is not taken by a
// load. Loads go straight to memory; when a buffered entry holds the same
// address the youngest such entry is forwarded so the core never sees stale
// data.
//
// Optional feature (macro SB_FWD_EN):
//   defined   : loads that hit a buffered address are forwarded (LdHit=1).
//   undefined : no compare-select path, LdHit=0. A load that hits a buffered
//               address is stalled and the port drains until no hit remains.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   Ewr, Erd, Addr,   core store / load request, address, store data
//   RDir
//   Stall             request not accepted this cycle (core holds it)
//   LdData, LdHit     combinational load result, forwarded-from-buffer flag
//   Full, Empty       registered occupancy flags
//   MemEwr, MemErd,   data memory write / read enables, address, write data
//   MemAddr, MemRDir
//   MemMOut           combinational read data from data memory
// -----------------------------------------------------------------------------

// One buffer slot: holds an {addr, data} pair and compares its address
// against the current load address.
module store_buffer_entry #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] cmp_addr,
  output logic [AW-1:0] ent_addr,
  output logic [DW-1:0] ent_data,
  output logic          match
);
  logic [AW-1:0] addr_d, addr_q;
  logic [DW-1:0] data_d, data_q;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (we) begin
      addr_d = wr_addr;
      data_d = wr_data;
    end
  end

  // Slot contents need no reset: validity is tracked by head/count.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign ent_addr = addr_q;
  assign ent_data = data_q;
  assign match    = (addr_q == cmp_addr);
endmodule

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Ewr,
  input  logic          Erd,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] RDir,
  output logic          Stall,
  output logic [DW-1:0] LdData,
  output logic          LdHit,
  output logic          Full,
  output logic          Empty,
  output logic          MemEwr,
  output logic          MemErd,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemRDir,
  input  logic [DW-1:0] MemMOut
);
  localparam int         PW      = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {M_IDLE, M_LOAD, M_DRAIN, M_FORCE} mode_e;

  logic [PW-1:0] head_d, head_q, tail_d, tail_q;
  logic [PW:0]   count_d, count_q;

  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [DEPTH-1:0]         ent_we, ent_match, ent_vld;

  logic  full, empty, push, pop;
  mode_e mode;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    // Slot g is live when its distance from head is below the count.
    assign ent_vld[g] = {1'b0, PW'(g) - head_q} < count_q;
    assign ent_we[g]  = push && (tail_q == PW'(g));

    store_buffer_entry #(.AW(AW), .DW(DW)) u_ent (
      .clk      (clk),
      .we       (ent_we[g]),
      .wr_addr  (Addr),
      .wr_data  (RDir),
      .cmp_addr (Addr),
      .ent_addr (ent_addr[g]),
      .ent_data (ent_data[g]),
      .match    (ent_match[g])
    );
  end

`ifdef SB_FWD_EN
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  // Walk oldest to youngest so the last live match (closest to tail) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = head_q;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (ent_vld[idx] && ent_match[idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end
`else
  logic ld_conflict;
  assign ld_conflict = |(ent_vld & ent_match);
`endif

  // Port arbitration and outputs.
  always_comb begin
    mode    = M_IDLE;
    Stall   = 1'b0;
    MemEwr  = 1'b0;
    MemErd  = 1'b0;
    MemAddr = Addr;
    MemRDir = '0;
    LdData  = '0;
    LdHit   = 1'b0;
    Full    = full;
    Empty   = empty;

    if (!rst_n) begin
      Stall = 1'b1;
      Full  = 1'b0;
      Empty = 1'b1;
    end else if (Ewr && Erd) begin
      // Illegal combined request: reject both and keep the port quiet.
      Stall = 1'b1;
    end else if (full) begin
      mode  = M_FORCE;
      Stall = Ewr | Erd;
    end else if (Erd) begin
`ifdef SB_FWD_EN
      mode = M_LOAD;
`else
      // Without forwarding, a load must wait until its address has drained.
      if (ld_conflict) begin
        mode  = M_DRAIN;
        Stall = 1'b1;
      end else begin
        mode = M_LOAD;
      end
`endif
    end else if (!empty) begin
      mode = M_DRAIN;
    end

    case (mode)
      M_LOAD: begin
        MemErd = 1'b1;
`ifdef SB_FWD_EN
        LdHit  = fwd_hit;
        LdData = fwd_hit ? fwd_data : MemMOut;
`else
        LdData = MemMOut;
`endif
      end
      M_DRAIN, M_FORCE: begin
        MemEwr  = 1'b1;
        MemAddr = ent_addr[head_q];
        MemRDir = ent_data[head_q];
      end
      default: ;
    endcase
  end

  assign push = rst_n && Ewr && !Erd && !full;
  assign pop  = MemEwr;

  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic, checked
// cycle by cycle against a queue-based model of the buffer and of memory.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Ewr = 1'b0, Erd = 1'b0;
  logic [AW-1:0] Addr = '0;
  logic [DW-1:0] RDir = '0;
  logic          Stall, LdHit, Full, Empty, MemEwr, MemErd;
  logic [DW-1:0] LdData, MemRDir, MemMOut;
  logic [AW-1:0] MemAddr;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .Ewr(Ewr), .Erd(Erd), .Addr(Addr), .RDir(RDir),
    .Stall(Stall), .LdData(LdData), .LdHit(LdHit), .Full(Full), .Empty(Empty),
    .MemEwr(MemEwr), .MemErd(MemErd), .MemAddr(MemAddr), .MemRDir(MemRDir),
    .MemMOut(MemMOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic [DW-1:0] mem     [16];  // memory the DUT really writes
  logic [DW-1:0] mem_ref [16];  // memory as the model expects it
  ent_t          q[$];          // model of buffered stores, oldest first
  int            n_tests = 0;
  int            n_fail  = 0;

  assign MemMOut = mem[MemAddr[3:0]];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock of stimulus: drive, predict, compare, then advance both sides.
  task automatic step(input logic ewr, input logic erd, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic rst);
    logic          e_stall, e_mewr, e_merd, e_hit, drain, push, hit, wr;
    logic [DW-1:0] e_ld, e_mdata, wd;
    logic [AW-1:0] e_maddr, wa;
    int            cnt;
    ent_t          e;
    @(negedge clk);
    Ewr = ewr; Erd = erd; Addr = a; RDir = d; rst_n = ~rst;
    #1;
    cnt = q.size();
    e_stall = 0; e_mewr = 0; e_merd = 0; e_hit = 0; e_ld = '0;
    e_maddr = a; e_mdata = '0; drain = 0; push = 0; hit = 0;
    if (rst) e_stall = 1;
    else if (ewr && erd) e_stall = 1;
    else if (cnt == DEPTH) begin
      drain = 1; e_stall = ewr | erd;
    end else if (erd) begin
      for (int i = 0; i < cnt; i++)
        if (q[i].a == a) begin hit = 1; e_ld = q[i].d; end
`ifdef SB_FWD_EN
      e_merd = 1; e_hit = hit;
      if (!hit) e_ld = mem_ref[a[3:0]];
`else
      if (hit) begin drain = 1; e_stall = 1; e_ld = '0; end
      else begin e_merd = 1; e_ld = mem_ref[a[3:0]]; end
`endif
    end else begin
      drain = (cnt > 0);
      push  = ewr;
    end
    if (drain) begin e_mewr = 1; e_maddr = q[0].a; e_mdata = q[0].d; end

    chk("stall",    64'(Stall),   64'(e_stall));
    chk("mem_ewr",  64'(MemEwr),  64'(e_mewr));
    chk("mem_erd",  64'(MemErd),  64'(e_merd));
    chk("mem_addr", 64'(MemAddr), 64'(e_maddr));
    chk("mem_rdir", 64'(MemRDir), 64'(e_mdata));
    chk("ld_data",  64'(LdData),  64'(e_ld));
    chk("ld_hit",   64'(LdHit),   64'(e_hit));
    chk("full",     64'(Full),    64'(!rst && cnt == DEPTH));
    chk("empty",    64'(Empty),   64'(rst || cnt == 0));

    wr = MemEwr; wa = MemAddr; wd = MemRDir;
    @(posedge clk);
    if (wr) mem[wa[3:0]] = wd;
    if (rst) q.delete();
    else begin
      if (drain) begin
        mem_ref[q[0].a[3:0]] = q[0].d;
        void'(q.pop_front());
      end
      if (push) begin
        e.a = a; e.d = d;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom;
      mem_ref[i] = mem[i];
    end

    // Reset, some pushes, reset again with requests present, then a load.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, AW'(i + 10), $urandom, 0);
    step(0, 1, 3, 0, 1);
    step(1, 0, 2, 32'hDEAD, 1);
    step(0, 1, 5, 0, 0);

    // Back-to-back stores 0x11..0x44 to addresses 1..4, then drain out.
    for (int i = 1; i <= 4; i++) step(1, 0, AW'(i), DW'(i * 32'h11), 0);
    idle(DEPTH + 1);

    // Stores interleaved with loads to the same addresses.
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, AW'(i), $urandom, 0);
      step(0, 1, AW'(i), 0, 0);
    end
    idle(DEPTH + 1);

    // Two stores to one address: load sees the younger, memory ends with it.
    step(1, 0, 7, 32'hAA, 0);
    step(1, 0, 7, 32'hBB, 0);
    step(0, 1, 7, 0, 0);
    step(0, 1, 7, 0, 0);
    idle(DEPTH + 1);
    step(0, 1, 7, 0, 0);

    // Illegal combined request, with and without buffered data.
    step(1, 1, 3, 32'h33, 0);
    step(1, 0, 3, 32'h13, 0);
    step(1, 1, 4, 32'h44, 0);
    idle(DEPTH + 1);

    // Load right after a store to the same address.
    step(1, 0, 9, 32'h5, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 9, 0, 0);

    // Random traffic with occasional reset.
    for (int n = 0; n < 500; n++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 2)       step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                             AW'($urandom_range(0, 15)), $urandom, 1);
      else if (op < 6)  step(1, 1, AW'($urandom_range(0, 15)), $urandom, 0);
      else if (op < 50) step(1, 0, AW'($urandom_range(0, 15)), $urandom, 0);
      else if (op < 80) step(0, 1, AW'($urandom_range(0, 15)), 0, 0);
      else              step(0, 0, AW'($urandom_range(0, 15)), 0, 0);
    end
    idle(DEPTH + 2);

    for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), 64'(mem[i]), 64'(mem_ref[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
